// File: rtl/cr_clint_tcipif_mst_pkg.sv
// Shared definitions for the CLINT tcipif initiator: register offsets,
// FSM state encoding and a small address helper.
package cr_clint_tcipif_mst_pkg;

  // CLINT register offsets
  localparam logic [15:0] CLINT_MSIP       = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMPLO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMPHI = 16'h4004;
  localparam logic [15:0] CLINT_MTIMELO    = 16'hbff8;
  localparam logic [15:0] CLINT_MTIMEHI    = 16'hbffc;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SGL    = 4'd1,
    ST_RD_HI0 = 4'd2,
    ST_RD_LO  = 4'd3,
    ST_RD_HI1 = 4'd4,
    ST_WR_LOM = 4'd5,
    ST_WR_HI  = 4'd6,
    ST_WR_LO  = 4'd7,
    ST_RSP    = 4'd8
  } mst_state_e;

  // Upper-word address of a dword-aligned base
  function automatic logic [15:0] hi_word(input logic [15:0] base);
    return base | 16'h0004;
  endfunction

endpackage

// File: rtl/cr_clint_mst_tmo.sv
// Per-beat timeout counter: cleared when a beat starts, counts cycles the
// beat is pending, and flags expiry in the cycle the limit is reached so the
// initiator can drop sel on that same edge.
module cr_clint_mst_tmo
  #(parameter int TIMEOUT = 16)
  (
    input  logic clint_clk,
    input  logic cpurst_b,
    input  logic start,
    input  logic busy,
    input  logic cmplt,
    output logic expire
  );

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Count pending cycles of the current beat
  always_ff @(posedge clint_clk) begin
    // NOTE: reset is sampled on the clock edge here, so it belongs inside the clocked block, not in the sensitivity list.
    if (!cpurst_b)
      tmo_cnt <= '0;
    else if (start)
      tmo_cnt <= '0;
    else if (busy && !cmplt)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // The beat's TIMEOUT-th pending cycle ends the beat at the coming edge
  assign expire = busy && !cmplt && (tmo_cnt == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/cr_clint_tcipif_mst.sv
// CLINT tcipif initiator: turns one 32/64-bit request into tcipif beats.
// 64-bit reads use hi-lo-hi with retry for a tear-free mtime; 64-bit writes
// park the low word at all-ones before writing hi then lo.
module cr_clint_tcipif_mst
  import cr_clint_tcipif_mst_pkg::*;
  #(parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3)
  (
    input  logic        clint_clk,
    input  logic        cpurst_b,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_write,
    input  logic        req_dword,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_vld,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tcipif_clint_sel,
    output logic [15:0] tcipif_clint_addr,
    output logic        tcipif_clint_write,
    output logic [31:0] tcipif_clint_wdata,
    input  logic        clint_tcipif_cmplt,
    input  logic [31:0] clint_tcipif_rdata
  );

  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  mst_state_e        state;
  logic [15:0]       base_q;
  logic [63:0]       wdata_q;
  logic [31:0]       hi0_q;
  logic [31:0]       lo_q;
  logic [RTY_W-1:0]  retry_cnt;
  logic              beat_done;
  logic              misalign;
  logic              tmo_start;
  logic              tmo_expire;

  assign req_rdy   = (state == ST_IDLE);
  assign beat_done = tcipif_clint_sel && clint_tcipif_cmplt;
  assign misalign  = req_dword && req_addr[2];
  assign tmo_start = (req_rdy && req_vld && !misalign) || beat_done;

  cr_clint_mst_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clint_clk (clint_clk),
    .cpurst_b  (cpurst_b),
    .start     (tmo_start),
    .busy      (tcipif_clint_sel),
    .cmplt     (clint_tcipif_cmplt),
    .expire    (tmo_expire)
  );

  // Request sequencing FSM with registered bus and response outputs
  always_ff @(posedge clint_clk) begin
    // NOTE: captured data registers are reset too, so nothing stale can leak into a later response.
    if (!cpurst_b) begin
      state              <= ST_IDLE;
      base_q             <= '0;
      wdata_q            <= '0;
      hi0_q              <= '0;
      lo_q               <= '0;
      retry_cnt          <= '0;
      rsp_vld            <= 1'b0;
      rsp_rdata          <= '0;
      rsp_err            <= 1'b0;
      tcipif_clint_sel   <= 1'b0;
      tcipif_clint_addr  <= '0;
      tcipif_clint_write <= 1'b0;
      tcipif_clint_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      rsp_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_vld) begin
            base_q    <= {req_addr[15:3], 3'b000};
            wdata_q   <= req_wdata;
            retry_cnt <= '0;
            if (misalign) begin
              state     <= ST_RSP;
              rsp_vld   <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (!req_dword) begin
              state              <= ST_SGL;
              tcipif_clint_sel   <= 1'b1;
              tcipif_clint_addr  <= req_addr;
              tcipif_clint_write <= req_write;
              tcipif_clint_wdata <= req_wdata[31:0];
            end else if (!req_write) begin
              state              <= ST_RD_HI0;
              tcipif_clint_sel   <= 1'b1;
              tcipif_clint_addr  <= hi_word({req_addr[15:3], 3'b000});
              tcipif_clint_write <= 1'b0;
              tcipif_clint_wdata <= '0;
            end else begin
              state              <= ST_WR_LOM;
              tcipif_clint_sel   <= 1'b1;
              tcipif_clint_addr  <= {req_addr[15:3], 3'b000};
              tcipif_clint_write <= 1'b1;
              tcipif_clint_wdata <= 32'hFFFF_FFFF;
            end
          end
        end

        ST_RSP: begin
          state     <= ST_IDLE;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end

        default: begin
          if (tmo_expire) begin
            tcipif_clint_sel <= 1'b0;
            state            <= ST_RSP;
            rsp_vld          <= 1'b1;
            rsp_err          <= 1'b1;
            rsp_rdata        <= '0;
          end else if (beat_done) begin
            case (state)
              ST_SGL: begin
                tcipif_clint_sel <= 1'b0;
                state            <= ST_RSP;
                rsp_vld          <= 1'b1;
                rsp_err          <= 1'b0;
                rsp_rdata        <= tcipif_clint_write ? 64'h0 : {32'h0, clint_tcipif_rdata};
              end
              ST_RD_HI0: begin
                hi0_q             <= clint_tcipif_rdata;
                tcipif_clint_addr <= base_q;
                state             <= ST_RD_LO;
              end
              ST_RD_LO: begin
                lo_q              <= clint_tcipif_rdata;
                tcipif_clint_addr <= hi_word(base_q);
                state             <= ST_RD_HI1;
              end
              ST_RD_HI1: begin
                if (clint_tcipif_rdata != hi0_q && retry_cnt < RTY_W'(MAX_RETRY)) begin
                  // High word moved between reads: re-read low against the new high
                  hi0_q             <= clint_tcipif_rdata;
                  retry_cnt         <= retry_cnt + 1'b1;
                  tcipif_clint_addr <= base_q;
                  state             <= ST_RD_LO;
                end else begin
                  tcipif_clint_sel <= 1'b0;
                  state            <= ST_RSP;
                  rsp_vld          <= 1'b1;
                  rsp_err          <= (clint_tcipif_rdata != hi0_q);
                  rsp_rdata        <= {clint_tcipif_rdata, lo_q};
                end
              end
              ST_WR_LOM: begin
                tcipif_clint_addr  <= hi_word(base_q);
                tcipif_clint_wdata <= wdata_q[63:32];
                state              <= ST_WR_HI;
              end
              ST_WR_HI: begin
                tcipif_clint_addr  <= base_q;
                tcipif_clint_wdata <= wdata_q[31:0];
                state              <= ST_WR_LO;
              end
              default: begin
                tcipif_clint_sel <= 1'b0;
                state            <= ST_RSP;
                rsp_vld          <= 1'b1;
                rsp_err          <= 1'b0;
                rsp_rdata        <= '0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_clint_tcipif_mst.sv
// Directed bench for the CLINT tcipif initiator with a behavioural slave
// that can return fixed data, a ticking mtime, a high word that changes on
// every beat, wait states, or never complete.
module tb_cr_clint_tcipif_mst;
  import cr_clint_tcipif_mst_pkg::*;

  localparam int M_FIXED = 0;
  localparam int M_MTIME = 1;
  localparam int M_HICHG = 2;
  localparam int M_DEAD  = 3;

  logic        clint_clk = 1'b0;
  logic        cpurst_b;
  logic        req_vld;
  logic        req_rdy;
  logic        req_write;
  logic        req_dword;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_vld;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        tcipif_clint_sel;
  logic [15:0] tcipif_clint_addr;
  logic        tcipif_clint_write;
  logic [31:0] tcipif_clint_wdata;
  logic        clint_tcipif_cmplt;
  logic [31:0] clint_tcipif_rdata;

  int          n_cmp = 0;
  int          n_fail = 0;

  int          slv_mode = M_FIXED;
  int          slv_wait = 0;
  logic [31:0] slv_fixed = 32'h0;
  int          beat_idx = 0;
  int          beat_base = 0;
  int          age = 0;
  logic [63:0] mt;
  logic [15:0] log_addr  [0:15];
  logic [31:0] log_wdata [0:15];
  logic        log_write [0:15];

  cr_clint_tcipif_mst dut (
    .clint_clk          (clint_clk),
    .cpurst_b           (cpurst_b),
    .req_vld            (req_vld),
    .req_rdy            (req_rdy),
    .req_write          (req_write),
    .req_dword          (req_dword),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .rsp_vld            (rsp_vld),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .tcipif_clint_sel   (tcipif_clint_sel),
    .tcipif_clint_addr  (tcipif_clint_addr),
    .tcipif_clint_write (tcipif_clint_write),
    .tcipif_clint_wdata (tcipif_clint_wdata),
    .clint_tcipif_cmplt (clint_tcipif_cmplt),
    .clint_tcipif_rdata (clint_tcipif_rdata)
  );

  always #5 clint_clk = ~clint_clk;

  // Slave handshake: complete after slv_wait pending cycles unless dead
  assign clint_tcipif_cmplt = tcipif_clint_sel && (slv_mode != M_DEAD) && (age >= slv_wait);

  // Slave read data
  always_comb begin
    mt = (beat_idx == beat_base) ? 64'h0000_0001_FFFF_FFFF : 64'h0000_0002_0000_0000;
    clint_tcipif_rdata = 32'h0;
    case (slv_mode)
      M_FIXED: clint_tcipif_rdata = slv_fixed;
      M_MTIME: clint_tcipif_rdata = tcipif_clint_addr[2] ? mt[63:32] : mt[31:0];
      M_HICHG: clint_tcipif_rdata = tcipif_clint_addr[2] ? 32'(beat_idx - beat_base) : 32'h55;
      default: clint_tcipif_rdata = 32'h0;
    endcase
  end

  // Slave bookkeeping: wait-state age and completed-beat log
  always @(posedge clint_clk) begin
    if (!tcipif_clint_sel || clint_tcipif_cmplt) age <= 0;
    else                                         age <= age + 1;
    if (tcipif_clint_sel && clint_tcipif_cmplt) begin
      if (beat_idx - beat_base < 16) begin
        log_addr[beat_idx - beat_base]  <= tcipif_clint_addr;
        log_wdata[beat_idx - beat_base] <= tcipif_clint_wdata;
        log_write[beat_idx - beat_base] <= tcipif_clint_write;
      end
      beat_idx <= beat_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; returns latency in cycles after the accept edge,
  // response data/err, sel-high cycle count and completed beat count
  task automatic do_req(input string tag, input logic wr, input logic dw,
                        input logic [15:0] addr, input logic [63:0] wd,
                        output int lat, output logic [63:0] rd, output logic err,
                        output int sel_cyc, output int beats);
    bit seen = 0;
    @(negedge clint_clk);
    beat_base = beat_idx;
    check({tag, "_rdy"}, {63'h0, req_rdy}, 64'h1);
    req_vld = 1'b1; req_write = wr; req_dword = dw; req_addr = addr; req_wdata = wd;
    @(posedge clint_clk); #1;
    req_vld = 1'b0;
    lat = 0; sel_cyc = 0; rd = '0; err = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      if (k > 1) begin @(posedge clint_clk); #1; end
      if (tcipif_clint_sel) sel_cyc++;
      if (rsp_vld) begin seen = 1; lat = k; rd = rsp_rdata; err = rsp_err; end
    end
    check({tag, "_rsp_seen"}, {63'h0, seen}, 64'h1);
    @(posedge clint_clk); #1;
    check({tag, "_pulse"}, {62'h0, rsp_vld, req_rdy}, 64'h1);
    beats = beat_idx - beat_base;
  endtask

  int          lat, sel_cyc, beats;
  logic [63:0] rd;
  logic        err;

  initial begin
    cpurst_b = 1'b0; req_vld = 1'b0; req_write = 1'b0; req_dword = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clint_clk);
    #1;
    check("rst_sel",   {63'h0, tcipif_clint_sel}, 64'h0);
    check("rst_rsp",   {62'h0, rsp_vld, rsp_err}, 64'h0);
    check("rst_rdata", rsp_rdata, 64'h0);
    check("rst_bus",   {15'h0, tcipif_clint_write, tcipif_clint_addr, tcipif_clint_wdata}, 64'h0);
    check("rst_rdy",   {63'h0, req_rdy}, 64'h1);
    @(negedge clint_clk); cpurst_b = 1'b1;

    // 32-bit read, zero-wait
    slv_mode = M_FIXED; slv_fixed = 32'h1234_5678;
    do_req("rd32", 1'b0, 1'b0, CLINT_MTIMECMPLO, 64'h0, lat, rd, err, sel_cyc, beats);
    check("rd32_lat", 64'(lat), 64'd2);
    check("rd32_data", rd, 64'h0000_0000_1234_5678);
    check("rd32_err", {63'h0, err}, 64'h0);
    check("rd32_addr", {48'h0, log_addr[0]}, 64'h4000);

    // 32-bit read with one wait state
    slv_wait = 1; slv_fixed = 32'hCAFE_F00D;
    do_req("rd32w", 1'b0, 1'b0, CLINT_MSIP, 64'h0, lat, rd, err, sel_cyc, beats);
    check("rd32w_lat", 64'(lat), 64'd3);
    check("rd32w_data", rd, 64'h0000_0000_CAFE_F00D);
    slv_wait = 0;

    // 32-bit write: data goes out, response data is zero
    do_req("wr32", 1'b1, 1'b0, CLINT_MSIP, 64'hFFFF_FFFF_0000_0001, lat, rd, err, sel_cyc, beats);
    check("wr32_lat", 64'(lat), 64'd2);
    check("wr32_data", rd, 64'h0);
    check("wr32_beat", {15'h0, log_write[0], log_addr[0], log_wdata[0]}, {15'h0, 1'b1, 16'h0000, 32'h0000_0001});

    // 64-bit mtime read with a carry between beats: one retry
    slv_mode = M_MTIME;
    do_req("rd64", 1'b0, 1'b1, CLINT_MTIMELO, 64'h0, lat, rd, err, sel_cyc, beats);
    check("rd64_lat", 64'(lat), 64'd6);
    check("rd64_data", rd, 64'h0000_0002_0000_0000);
    check("rd64_err", {63'h0, err}, 64'h0);
    check("rd64_beats", 64'(beats), 64'd5);
    check("rd64_a0", {48'h0, log_addr[0]}, 64'hbffc);
    check("rd64_a1", {48'h0, log_addr[1]}, 64'hbff8);

    // 64-bit write sequence
    slv_mode = M_FIXED;
    do_req("wr64", 1'b1, 1'b1, CLINT_MTIMECMPLO, 64'hAAAA_BBBB_CCCC_DDDD, lat, rd, err, sel_cyc, beats);
    check("wr64_lat", 64'(lat), 64'd4);
    check("wr64_err", {63'h0, err}, 64'h0);
    check("wr64_beats", 64'(beats), 64'd3);
    check("wr64_b0", {log_write[0], log_addr[0], log_wdata[0]}, {1'b1, 16'h4000, 32'hFFFF_FFFF});
    check("wr64_b1", {log_write[1], log_addr[1], log_wdata[1]}, {1'b1, 16'h4004, 32'hAAAA_BBBB});
    check("wr64_b2", {log_write[2], log_addr[2], log_wdata[2]}, {1'b1, 16'h4000, 32'hCCCC_DDDD});

    // Dead slave: timeout
    slv_mode = M_DEAD;
    do_req("tmo", 1'b0, 1'b0, CLINT_MSIP, 64'h0, lat, rd, err, sel_cyc, beats);
    check("tmo_sel_cyc", 64'(sel_cyc), 64'd16);
    check("tmo_lat", 64'(lat), 64'd17);
    check("tmo_err", {63'h0, err}, 64'h1);
    check("tmo_data", rd, 64'h0);

    // Misaligned 64-bit access: no bus beat
    slv_mode = M_FIXED;
    do_req("mis", 1'b0, 1'b1, CLINT_MTIMECMPHI, 64'h0, lat, rd, err, sel_cyc, beats);
    check("mis_lat", 64'(lat), 64'd1);
    check("mis_err", {63'h0, err}, 64'h1);
    check("mis_sel_cyc", 64'(sel_cyc), 64'd0);
    check("mis_data", rd, 64'h0);

    // High word changes on every beat: retries exhausted
    slv_mode = M_HICHG;
    do_req("rty", 1'b0, 1'b1, CLINT_MTIMELO, 64'h0, lat, rd, err, sel_cyc, beats);
    check("rty_lat", 64'(lat), 64'd10);
    check("rty_err", {63'h0, err}, 64'h1);
    check("rty_data", rd, 64'h0000_0008_0000_0055);
    check("rty_beats", 64'(beats), 64'd9);

    // Reset during WR_HI
    slv_mode = M_FIXED;
    @(negedge clint_clk);
    req_vld = 1'b1; req_write = 1'b1; req_dword = 1'b1;
    req_addr = CLINT_MTIMECMPLO; req_wdata = 64'h1111_2222_3333_4444;
    @(posedge clint_clk); #1;
    req_vld = 1'b0;
    check("mrst_lom", {tcipif_clint_addr, tcipif_clint_wdata}, {16'h0, 16'h4000, 32'hFFFF_FFFF});
    @(posedge clint_clk); #1;
    check("mrst_hi", {15'h0, tcipif_clint_sel, tcipif_clint_addr, tcipif_clint_wdata}, {15'h0, 1'b1, 16'h4004, 32'h1111_2222});
    cpurst_b = 1'b0;
    @(posedge clint_clk); #1;
    check("mrst_sel", {62'h0, tcipif_clint_sel, rsp_vld}, 64'h0);
    cpurst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clint_clk); #1;
      check("mrst_quiet", {61'h0, rsp_vld, tcipif_clint_sel, req_rdy}, 64'h1);
    end

    // Recovery after reset
    slv_fixed = 32'h0BAD_BEEF;
    do_req("post", 1'b0, 1'b0, CLINT_MTIMEHI, 64'h0, lat, rd, err, sel_cyc, beats);
    check("post_lat", 64'(lat), 64'd2);
    check("post_data", rd, 64'h0000_0000_0BAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
